// File: rtl/la_pkg.sv
// Shared definitions for the logic analyzer capture path: record kinds,
// record width helper and the default timestamp width.
package la_pkg;

  localparam int unsigned DEFAULT_TIME_LENGTH = 24;

  typedef enum logic [1:0] {
    KIND_CHANGE      = 2'b00,
    KIND_START       = 2'b01,
    KIND_WRAP        = 2'b10,
    KIND_CHANGE_WRAP = 2'b11
  } kind_e;

  // Record layout is {kind[1:0], time, channels}
  function automatic int unsigned record_width(input int unsigned time_length,
                                               input int unsigned channels);
    return 2 + time_length + channels;
  endfunction

endpackage

// File: rtl/event_encoder_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head word is read straight
// from the storage registers, so data/valid never depend on the pop input.
// Push and pop in the same cycle are legal even when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  // Guard against popping empty or pushing full without a matching pop
  always_comb begin
    pop_ok  = pop && valid;
    push_ok = push && ((count != FULL_COUNT) || pop_ok);
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Head of queue presented directly from storage
  always_comb begin
    data  = mem[rd_ptr];
    valid = (count != '0);
  end

endmodule

// File: rtl/event_encoder.sv
// Probe event encoder: synchronises the channels, detects changes, run
// starts and timestamp wraps, and queues timestamped records for a
// valid/ready consumer. Records that find the queue full are dropped and
// flagged through a sticky overflow bit.
module event_encoder
  import la_pkg::*;
#(
  parameter int unsigned TIME_LENGTH = DEFAULT_TIME_LENGTH,
  parameter int unsigned CHANNELS    = 8,
  parameter int unsigned DEPTH       = 16
) (
  input  logic                                            i_clk,
  input  logic                                            i_rst_n,
  input  logic                                            i_run,
  input  logic [TIME_LENGTH-1:0]                          i_time,
  input  logic [CHANNELS-1:0]                             i_channels,
  output logic [record_width(TIME_LENGTH, CHANNELS)-1:0]  o_data,
  output logic                                            o_valid,
  input  logic                                            i_ready,
  output logic                                            o_overflow,
  output logic [$clog2(DEPTH):0]                          o_count
);

  localparam int unsigned REC_W = record_width(TIME_LENGTH, CHANNELS);
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [CHANNELS-1:0]    s1;
  logic [CHANNELS-1:0]    s2;
  logic [CHANNELS-1:0]    last;
  logic [TIME_LENGTH-1:0] prev_time;
  logic                   run_q;

  logic                   start_ev;
  logic                   change_ev;
  logic                   wrap_ev;
  logic                   push_req;
  logic                   pop;
  logic                   accept;
  logic                   drop;
  kind_e                  kind;
  logic [REC_W-1:0]       record;

  // Two-flop synchroniser for the asynchronous probe inputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= i_channels;
      s2 <= s1;
    end
  end

  // Capture history: last recorded channels, previous time, delayed run.
  // While run is low last follows s2 so a restart sees no stale change.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last      <= '0;
      prev_time <= '0;
      run_q     <= 1'b0;
    end else begin
      if (!i_run || start_ev || change_ev) last <= s2;
      prev_time <= i_time;
      run_q     <= i_run;
    end
  end

  // Event detection and record kind priority
  always_comb begin
    start_ev  = i_run && !run_q;
    change_ev = i_run && (s2 != last);
    wrap_ev   = i_run && run_q && (i_time != prev_time) && (i_time == '0);
    push_req  = start_ev || change_ev || wrap_ev;

    kind = KIND_CHANGE;
    if (start_ev)                  kind = KIND_START;
    else if (change_ev && wrap_ev) kind = KIND_CHANGE_WRAP;
    else if (wrap_ev)              kind = KIND_WRAP;

    record = {kind, i_time, s2};
  end

  // Push acceptance: room in the queue, or a pop frees a slot this cycle
  always_comb begin
    pop    = o_valid && i_ready;
    accept = (o_count < FULL_COUNT) || pop;
    drop   = push_req && !accept;
  end

  // Sticky overflow; a drop in the same cycle as a START still flags it
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)      o_overflow <= 1'b0;
    else if (drop)     o_overflow <= 1'b1;
    else if (start_ev) o_overflow <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push_req && accept),
    .push_data (record),
    .pop       (pop),
    .data      (o_data),
    .valid     (o_valid),
    .count     (o_count)
  );

endmodule

// File: tb/tb_event_encoder.sv
// Directed bench for event_encoder: a vector table for change/wrap records
// plus hand-written sequences for reset, overflow, full-throughput, run-low
// draining and mid-operation reset.
module tb_event_encoder;

  localparam int unsigned TL = 24;
  localparam int unsigned CH = 8;
  localparam int unsigned DP = 16;
  localparam int unsigned RW = 2 + TL + CH;
  localparam int unsigned CW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic          ready;
  logic [TL-1:0] tme;
  logic [CH-1:0] ch;
  logic [RW-1:0] data;
  logic          valid;
  logic          overflow;
  logic [CW-1:0] count;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [TL-1:0] t;
    logic [CH-1:0] c;
    logic          ev;
    logic [RW-1:0] ed;
    logic [CW-1:0] ec;
  } vec_t;

  vec_t tbl [16];

  always #5 clk = ~clk;

  event_encoder #(
    .TIME_LENGTH (TL),
    .CHANNELS    (CH),
    .DEPTH       (DP)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_run      (run),
    .i_time     (tme),
    .i_channels (ch),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_overflow (overflow),
    .o_count    (count)
  );

  function automatic logic [RW-1:0] rec(input logic [1:0] k, input logic [TL-1:0] t,
                                        input logic [CH-1:0] c);
    return {k, t, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!valid && n < 8) begin
      tick();
      n++;
    end
    chk(name, 64'(valid), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Change / wrap / change+wrap / back-to-back records with ready high
    tbl[0]  = '{24'd7,        8'hA5, 1'b0, '0,                          '0};
    tbl[1]  = '{24'd7,        8'hA5, 1'b0, '0,                          '0};
    tbl[2]  = '{24'd7,        8'hA5, 1'b1, rec(2'b00, 24'd7, 8'hA5),    5'd1};
    tbl[3]  = '{24'd8,        8'hA5, 1'b0, '0,                          '0};
    tbl[4]  = '{24'hFFFFFF,   8'hA5, 1'b0, '0,                          '0};
    tbl[5]  = '{24'd0,        8'hA5, 1'b1, rec(2'b10, 24'd0, 8'hA5),    5'd1};
    tbl[6]  = '{24'd0,        8'hA5, 1'b0, '0,                          '0};
    tbl[7]  = '{24'hFFFFFF,   8'h5A, 1'b0, '0,                          '0};
    tbl[8]  = '{24'hFFFFFF,   8'h5A, 1'b0, '0,                          '0};
    tbl[9]  = '{24'd0,        8'h5A, 1'b1, rec(2'b11, 24'd0, 8'h5A),    5'd1};
    tbl[10] = '{24'd1,        8'h5A, 1'b0, '0,                          '0};
    tbl[11] = '{24'd2,        8'h3C, 1'b0, '0,                          '0};
    tbl[12] = '{24'd3,        8'hC3, 1'b0, '0,                          '0};
    tbl[13] = '{24'd4,        8'hC3, 1'b1, rec(2'b00, 24'd4, 8'h3C),    5'd1};
    tbl[14] = '{24'd5,        8'hC3, 1'b1, rec(2'b00, 24'd5, 8'hC3),    5'd1};
    tbl[15] = '{24'd6,        8'hC3, 1'b0, '0,                          '0};

    // Reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run   = 1'($urandom);
      ready = 1'($urandom);
      tme   = TL'($urandom);
      ch    = CH'($urandom);
      tick();
      chk("reset_valid", 64'(valid), 64'd0);
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_overflow", 64'(overflow), 64'd0);
    end
    chk("reset_data", 64'(data), 64'd0);
    run = 1'b0; ready = 1'b0; tme = '0; ch = 8'h00;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("idle_valid", 64'(valid), 64'd0);

    // START record
    run = 1'b1;
    wait_valid("start_valid");
    chk("start_data", 64'(data), 64'(rec(2'b01, 24'd0, 8'h00)));
    chk("start_count", 64'(count), 64'd1);
    ready = 1'b1;
    tick();

    // Table-driven change/wrap vectors
    for (int k = 0; k < 16; k++) begin
      tme = tbl[k].t;
      ch  = tbl[k].c;
      tick();
      chk($sformatf("tbl%0d_valid", k), 64'(valid), 64'(tbl[k].ev));
      chk($sformatf("tbl%0d_count", k), 64'(count), 64'(tbl[k].ec));
      if (tbl[k].ev) chk($sformatf("tbl%0d_data", k), 64'(data), 64'(tbl[k].ed));
    end

    // Overflow: DEPTH+3 changes with ready low
    ready = 1'b0;
    for (int i = 0; i < 21; i++) begin
      tme = TL'(100 + i);
      ch  = (i < 19) ? CH'(i + 1) : CH'(19);
      tick();
      if (i == 17) begin
        chk("ovf_count_full", 64'(count), 64'd16);
        chk("ovf_before_drop", 64'(overflow), 64'd0);
      end
      if (i == 18) chk("ovf_after_drop", 64'(overflow), 64'd1);
    end
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
    ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("drain%0d_data", j), 64'(data), 64'(rec(2'b00, TL'(102 + j), CH'(j + 1))));
      tick();
    end
    chk("drain_valid", 64'(valid), 64'd0);
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_ovf_sticky", 64'(overflow), 64'd1);

    // New START clears overflow
    ready = 1'b0; run = 1'b0; tme = 24'd200;
    tick();
    tick();
    run = 1'b1;
    wait_valid("restart_valid");
    chk("restart_data", 64'(data), 64'(rec(2'b01, 24'd200, 8'h13)));
    chk("restart_ovf_clear", 64'(overflow), 64'd0);
    ready = 1'b1;
    tick();

    // Full FIFO with simultaneous push and pop every cycle
    for (int i = 0; i < 30; i++) begin
      tme   = TL'(300 + i);
      ch    = CH'(8'h20 + i);
      ready = (i >= 18);
      if (i >= 18)
        chk($sformatf("full%0d_data", i), 64'(data),
            64'(rec(2'b00, TL'(302 + i - 18), CH'(8'h20 + i - 18))));
      tick();
      if (i >= 17) begin
        chk($sformatf("full%0d_count", i), 64'(count), 64'd16);
        chk($sformatf("full%0d_ovf", i), 64'(overflow), 64'd0);
      end
    end

    // Run low: channels toggle, nothing new is pushed, backlog drains
    run = 1'b0; ready = 1'b1;
    for (int m = 0; m < 20; m++) begin
      ch  = (m % 2 == 1) ? 8'h55 : 8'hAA;
      tme = TL'(400 + m);
      if (m < 16)
        chk($sformatf("runlow%0d_data", m), 64'(data),
            64'(rec(2'b00, TL'(314 + m), CH'(8'h2C + m))));
      tick();
    end
    chk("runlow_valid", 64'(valid), 64'd0);
    chk("runlow_count", 64'(count), 64'd0);

    // Mid-operation reset
    ready = 1'b0; ch = 8'h55; tme = 24'd500;
    tick();
    tick();
    run = 1'b1;
    wait_valid("pre_reset_start");
    chk("pre_reset_data", 64'(data), 64'(rec(2'b01, 24'd500, 8'h55)));
    ch = 8'h66;
    for (int i = 0; i < 3; i++) tick();
    chk("pre_reset_count", 64'(count), 64'd2);
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", 64'(valid), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_ovf", 64'(overflow), 64'd0);
    chk("midrst_data", 64'(data), 64'd0);
    rst_n = 1'b1;
    wait_valid("post_reset_valid");
    chk("post_reset_kind", 64'(data[RW-1 -: 2]), 64'(2'b01));
    chk("post_reset_count", 64'(count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
